ahb_vector_fetch: RTL and testbench
===================================

// Module: ahb_vector_fetch
// PURPOSE
//  AHB-Lite read-only initiator that fetches entries from the vector table responder (VT_BASE).
//  After reset it reads the initial SP (offset 0x0) and reset PC (offset 0x4).
//  It then serves exception vector lookups: exc_id N -> word at VT_BASE + 4*N (NMI=2, fault=3, IRQk=16+k).
//  Sits between the interrupt/boot controller and the AHB-Lite fabric; one outstanding transfer at a time.
// PARAMETERS
//  VT_BASE    32'h0000_0000  byte base address of the vector table (word aligned)
//  MAX_RETRY  2              re-issues of a transfer after an ERROR response before reporting failure (0..7)
// PORTS
//  hclk       in   1   clock, all state on rising edge
//  hreset     in   1   asynchronous reset, active-high
//  htrans     out  2   2'b00 IDLE / 2'b10 NONSEQ; never SEQ or BUSY
//  haddr      out  32  transfer address
//  hsize      out  3   constant 3'b010 (word)
//  hwrite     out  1   constant 0
//  hrdata     in   32  read data, valid in data phase when hready=1 and hresp=0
//  hready     in   1   transfer done / stall
//  hresp      in   1   error response (two-cycle: hready=0,hresp=1 then hready=1,hresp=1)
//  exc_req    in   1   vector lookup request, held until exc_ack
//  exc_id     in   5   exception number, sampled with exc_req when accepted
//  exc_ack    out  1   one-cycle pulse: request accepted
//  vec_valid  out  1   one-cycle pulse: vec_addr/vec_err valid
//  vec_addr   out  32  fetched vector, held until next vec_valid
//  vec_err    out  1   qualifies vec_valid: fetch failed after retries (vec_addr=0)
//  boot_sp    out  32  fetched initial SP, held
//  boot_pc    out  32  fetched reset PC, held
//  boot_done  out  1   level, set once both boot fetches finished (success or failure)
//  boot_err   out  1   level, a boot fetch failed after retries (failed value reads 0)
// BEHAVIOUR
//  Reset: htrans=IDLE, haddr=VT_BASE, all other outputs 0; FSM=BOOT_SP_A; retry count 0.
//  All outputs registered. States: BOOT_SP_A, BOOT_SP_D, BOOT_PC_A, BOOT_PC_D, IDLE, EXC_A, EXC_D.
//  *_A (address phase): htrans=NONSEQ, haddr=target. Advance to *_D only on hready=1; else hold.
//  *_D (data phase): htrans=IDLE. Wait while hready=0 and hresp=0.
//   - hready=1, hresp=0: capture hrdata, clear retry count, go to next state.
//   - hresp=1 with hready=0: drive htrans=IDLE next cycle; no new transfer until hready=1.
//   - hresp=1 with hready=1: if retry<MAX_RETRY, retry++, return to same *_A; else fail.
//  Boot order: SP (VT_BASE+0x0) then PC (VT_BASE+0x4); boot_done rises the cycle after PC data phase ends.
//  IDLE: exc_req sampled only when boot_done=1; accepted at edge N -> exc_ack=1 and NONSEQ,
//   haddr=VT_BASE+{exc_id,2'b00} in cycle N+1. Zero-wait responder -> vec_valid in cycle N+3.
//  exc_req while boot_done=0 or FSM not IDLE: ignored, no ack (requester holds it).
//  Completion and a pending exc_req: the next acceptance is no earlier than the cycle after vec_valid.
//  Address arithmetic: 32-bit, wraps modulo 2^32; exc_id not range-checked (ids 0/1 read SP/PC).
//  Failure: vec_valid=1, vec_err=1, vec_addr=0; boot failure sets boot_err, value 0, boot continues.
//  hreset mid-transfer: outputs return to reset values asynchronously; boot sequence restarts.
// TESTING
//  T1 reset release, zero-wait slave (SP=0x2000_1000, PC=0x0000_0101) -> NONSEQ @0x0, @0x4;
//     boot_sp/boot_pc match, boot_done=1, boot_err=0, and no other transfers.
//  T2 exc_id=18 (IRQ2), slave word 0x0000_0A01 -> exc_ack at N+1, haddr=0x48, vec_valid N+3,
//     vec_addr=0x0000_0A01, vec_err=0.
//  T3 slave inserts 3 wait states on IRQ15 (addr 0x7C) -> htrans IDLE during waits; vec_valid 3 cycles later.
//  T4 slave errors every attempt on 0x48, MAX_RETRY=2 -> 3 NONSEQ transfers total;
//     vec_valid=1, vec_err=1, vec_addr=0.
//  T5 exc_req asserted during boot -> no ack until boot_done; then ack and fetch of the correct address.
//  T6 hreset asserted in EXC_D -> htrans=IDLE, boot_done=0 immediately; after release, refetch @0x0, @0x4.

Source files
------------

// File: rtl/ahb_vector_fetch.sv
// ahb_vector_fetch: AHB-Lite read-only initiator for the vector table.
// Boots by reading the initial SP and reset PC, then serves exception
// vector lookups one transfer at a time, retrying ERROR responses.
module ahb_vector_fetch #(
    parameter logic [31:0] VT_BASE   = 32'h0000_0000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        hclk,
    input  logic        hreset,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic [2:0]  hsize,
    output logic        hwrite,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic        exc_req,
    input  logic [4:0]  exc_id,
    output logic        exc_ack,
    output logic        vec_valid,
    output logic [31:0] vec_addr,
    output logic        vec_err,
    output logic [31:0] boot_sp,
    output logic [31:0] boot_pc,
    output logic        boot_done,
    output logic        boot_err
);

    typedef enum logic [2:0] {
        BOOT_SP_A = 3'd0,
        BOOT_SP_D = 3'd1,
        BOOT_PC_A = 3'd2,
        BOOT_PC_D = 3'd3,
        IDLE      = 3'd4,
        EXC_A     = 3'd5,
        EXC_D     = 3'd6
    } state_t;

    localparam logic [1:0]  TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);
    localparam logic [31:0] PC_ADDR      = VT_BASE + 32'h0000_0004;

    state_t      state, state_next;
    logic [2:0]  retry, retry_next;
    logic [1:0]  htrans_next;
    logic [31:0] haddr_next;
    logic        exc_ack_next;
    logic        vec_valid_next;
    logic [31:0] vec_addr_next;
    logic        vec_err_next;
    logic [31:0] boot_sp_next;
    logic [31:0] boot_pc_next;
    logic        boot_done_next;
    logic        boot_err_next;

    logic addr_taken;
    logic data_ok;
    logic data_err;
    logic retry_left;

    // Word reads only; these never change.
    assign hsize  = 3'b010;
    assign hwrite = 1'b0;

    // An address phase only counts once NONSEQ is actually on the bus, which
    // keeps the first cycle after reset (htrans still IDLE) from being skipped.
    assign addr_taken = (htrans == TRANS_NONSEQ) && hready;
    assign data_ok    = hready && !hresp;
    assign data_err   = hready && hresp;
    assign retry_left = (retry < RETRY_LIMIT);

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_next     = state;
        retry_next     = retry;
        haddr_next     = haddr;
        exc_ack_next   = 1'b0;
        vec_valid_next = 1'b0;
        vec_addr_next  = vec_addr;
        vec_err_next   = 1'b0;
        boot_sp_next   = boot_sp;
        boot_pc_next   = boot_pc;
        boot_done_next = boot_done;
        boot_err_next  = boot_err;
        case (state)
            BOOT_SP_A: begin
                if (addr_taken) begin
                    state_next = BOOT_SP_D;
                end else begin
                    state_next = BOOT_SP_A;
                end
            end
            BOOT_SP_D: begin
                if (data_ok) begin
                    boot_sp_next = hrdata;
                    retry_next   = 3'd0;
                    haddr_next   = PC_ADDR;
                    state_next   = BOOT_PC_A;
                end else if (data_err) begin
                    if (retry_left) begin
                        retry_next = retry + 3'd1;
                        state_next = BOOT_SP_A;
                    end else begin
                        boot_sp_next  = 32'd0;
                        boot_err_next = 1'b1;
                        retry_next    = 3'd0;
                        haddr_next    = PC_ADDR;
                        state_next    = BOOT_PC_A;
                    end
                end else begin
                    state_next = BOOT_SP_D;
                end
            end
            BOOT_PC_A: begin
                if (addr_taken) begin
                    state_next = BOOT_PC_D;
                end else begin
                    state_next = BOOT_PC_A;
                end
            end
            BOOT_PC_D: begin
                if (data_ok) begin
                    boot_pc_next   = hrdata;
                    retry_next     = 3'd0;
                    boot_done_next = 1'b1;
                    state_next     = IDLE;
                end else if (data_err) begin
                    if (retry_left) begin
                        retry_next = retry + 3'd1;
                        state_next = BOOT_PC_A;
                    end else begin
                        boot_pc_next   = 32'd0;
                        boot_err_next  = 1'b1;
                        retry_next     = 3'd0;
                        boot_done_next = 1'b1;
                        state_next     = IDLE;
                    end
                end else begin
                    state_next = BOOT_PC_D;
                end
            end
            IDLE: begin
                // Holding off while vec_valid is high keeps a held request
                // from being accepted in the same cycle its result is reported.
                if (exc_req && boot_done && !vec_valid) begin
                    exc_ack_next = 1'b1;
                    haddr_next   = VT_BASE + {25'd0, exc_id, 2'b00};
                    state_next   = EXC_A;
                end else begin
                    state_next = IDLE;
                end
            end
            EXC_A: begin
                if (addr_taken) begin
                    state_next = EXC_D;
                end else begin
                    state_next = EXC_A;
                end
            end
            EXC_D: begin
                if (data_ok) begin
                    vec_valid_next = 1'b1;
                    vec_addr_next  = hrdata;
                    retry_next     = 3'd0;
                    state_next     = IDLE;
                end else if (data_err) begin
                    if (retry_left) begin
                        retry_next = retry + 3'd1;
                        state_next = EXC_A;
                    end else begin
                        vec_valid_next = 1'b1;
                        vec_err_next   = 1'b1;
                        vec_addr_next  = 32'd0;
                        retry_next     = 3'd0;
                        state_next     = IDLE;
                    end
                end else begin
                    state_next = EXC_D;
                end
            end
            default: begin
                state_next = BOOT_SP_A;
                retry_next = 3'd0;
                haddr_next = VT_BASE;
            end
        endcase
        // NONSEQ is presented in every cycle the FSM sits in an address state.
        htrans_next = ((state_next == BOOT_SP_A) || (state_next == BOOT_PC_A) ||
                       (state_next == EXC_A)) ? TRANS_NONSEQ : TRANS_IDLE;
    end

    // State, retry counter and registered outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= BOOT_SP_A;
            retry     <= 3'd0;
            htrans    <= TRANS_IDLE;
            haddr     <= VT_BASE;
            exc_ack   <= 1'b0;
            vec_valid <= 1'b0;
            vec_addr  <= 32'd0;
            vec_err   <= 1'b0;
            boot_sp   <= 32'd0;
            boot_pc   <= 32'd0;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
        end else begin
            state     <= state_next;
            retry     <= retry_next;
            htrans    <= htrans_next;
            haddr     <= haddr_next;
            exc_ack   <= exc_ack_next;
            vec_valid <= vec_valid_next;
            vec_addr  <= vec_addr_next;
            vec_err   <= vec_err_next;
            boot_sp   <= boot_sp_next;
            boot_pc   <= boot_pc_next;
            boot_done <= boot_done_next;
            boot_err  <= boot_err_next;
        end
    end

endmodule

// File: tb/tb_ahb_vector_fetch.sv
// Testbench for ahb_vector_fetch: a behavioural vector-table responder with
// per-entry wait states and error injection, plus a transaction-level model
// of the expected vector, error flag, transfer count and latency.
module tb_ahb_vector_fetch;

    localparam logic [31:0] VT_BASE   = 32'h0000_0000;
    localparam int          MAX_RETRY = 2;

    logic        hclk;
    logic        hreset;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        exc_req;
    logic [4:0]  exc_id;
    logic        exc_ack;
    logic        vec_valid;
    logic [31:0] vec_addr;
    logic        vec_err;
    logic [31:0] boot_sp;
    logic [31:0] boot_pc;
    logic        boot_done;
    logic        boot_err;

    // Responder contents: data word, wait states and pending error count per entry.
    logic [31:0] mem [32];
    int          waits [32];
    int          errs_left [32];
    logic [31:0] xfer_log [$];

    int checks = 0;
    int errors = 0;

    ahb_vector_fetch #(.VT_BASE(VT_BASE), .MAX_RETRY(MAX_RETRY)) dut (
        .hclk(hclk), .hreset(hreset), .htrans(htrans), .haddr(haddr),
        .hsize(hsize), .hwrite(hwrite), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .exc_req(exc_req), .exc_id(exc_id), .exc_ack(exc_ack),
        .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_err(vec_err),
        .boot_sp(boot_sp), .boot_pc(boot_pc), .boot_done(boot_done),
        .boot_err(boot_err)
    );

    // Clock.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Responder: decides at the falling edge whether an address phase is
    // completing, then drives the data-phase script just after the rising edge.
    initial begin : responder
        logic        acc;
        logic [31:0] acc_addr;
        int          idx;
        logic [33:0] script [$];
        logic [33:0] beat;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'd0;
        forever begin
            @(negedge hclk);
            acc      = (htrans == 2'b10) && hready && !hreset;
            acc_addr = haddr;
            @(posedge hclk);
            #1;
            if (hreset) begin
                script.delete();
            end else if (acc) begin
                xfer_log.push_back(acc_addr);
                idx = int'(acc_addr[6:2]);
                for (int i = 0; i < waits[idx]; i++) script.push_back({1'b0, 1'b0, 32'd0});
                if (errs_left[idx] > 0) begin
                    errs_left[idx]--;
                    script.push_back({1'b0, 1'b1, 32'd0});
                    script.push_back({1'b1, 1'b1, 32'd0});
                end else begin
                    script.push_back({1'b1, 1'b0, mem[idx]});
                end
            end
            if (script.size() > 0) begin
                beat = script.pop_front();
                {hready, hresp, hrdata} = beat;
            end else begin
                hready = 1'b1;
                hresp  = 1'b0;
                hrdata = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge hclk);
    endtask

    task automatic wait_boot();
        int n;
        n = 0;
        while (!boot_done && n < 100) begin
            tick();
            n++;
        end
        chk("boot_done_seen", 32'(boot_done), 32'd1);
    endtask

    // One vector lookup checked against the transaction-level model.
    task automatic do_req(input int id);
        int          w, e, att, nerr, len, n;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        w        = waits[id];
        e        = errs_left[id];
        exp_err  = (e > MAX_RETRY);
        att      = exp_err ? MAX_RETRY + 1 : e + 1;
        nerr     = exp_err ? att : e;
        len      = att * (1 + w) + 2 * nerr + (exp_err ? 0 : 1);
        exp_data = exp_err ? 32'd0 : mem[id];
        exp_addr = VT_BASE + 32'(id) * 32'd4;
        xfer_log.delete();
        exc_id  = 5'(id);
        exc_req = 1'b1;
        n = 0;
        while (!exc_ack && n < 20) begin
            tick();
            n++;
        end
        chk("req_ack_seen", 32'(exc_ack), 32'd1);
        chk("req_ack_addr", haddr, exp_addr);
        chk("req_ack_htrans", 32'(htrans), 32'd2);
        exc_req = 1'b0;
        n = 0;
        while (!vec_valid && n < 200) begin
            tick();
            n++;
        end
        chk("req_valid_seen", 32'(vec_valid), 32'd1);
        chk("req_latency", 32'(n), 32'(len));
        chk("req_vec_addr", vec_addr, exp_data);
        chk("req_vec_err", 32'(vec_err), 32'(exp_err));
        chk("req_xfer_count", 32'(xfer_log.size()), 32'(att));
        foreach (xfer_log[k]) chk("req_xfer_addr", xfer_log[k], exp_addr);
        tick();
        chk("req_valid_pulse", 32'(vec_valid), 32'd0);
        chk("req_vec_held", vec_addr, exp_data);
    endtask

    // Directed and randomized stimulus.
    initial begin : main
        int          id;
        int          n;
        logic        early;
        logic [31:0] w0, w1, w5;
        hreset  = 1'b1;
        exc_req = 1'b0;
        exc_id  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            mem[i]       = $urandom;
            waits[i]     = 0;
            errs_left[i] = 0;
        end
        mem[0]  = 32'h2000_1000;
        mem[1]  = 32'h0000_0101;
        mem[18] = 32'h0000_0A01;
        repeat (3) tick();

        // Reset values.
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, VT_BASE);
        chk("rst_hsize", 32'(hsize), 32'd2);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_exc_ack", 32'(exc_ack), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_vec_addr", vec_addr, 32'd0);
        chk("rst_vec_err", 32'(vec_err), 32'd0);
        chk("rst_boot_sp", boot_sp, 32'd0);
        chk("rst_boot_pc", boot_pc, 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_boot_err", 32'(boot_err), 32'd0);

        // T1: clean boot.
        xfer_log.delete();
        hreset = 1'b0;
        wait_boot();
        repeat (4) tick();
        chk("t1_boot_sp", boot_sp, 32'h2000_1000);
        chk("t1_boot_pc", boot_pc, 32'h0000_0101);
        chk("t1_boot_err", 32'(boot_err), 32'd0);
        chk("t1_xfer_count", 32'(xfer_log.size()), 32'd2);
        if (xfer_log.size() == 2) begin
            chk("t1_xfer0", xfer_log[0], VT_BASE);
            chk("t1_xfer1", xfer_log[1], VT_BASE + 32'd4);
        end else begin
            chk("t1_xfer_log_shape", 32'(xfer_log.size()), 32'd2);
        end

        // T2: exact cycle timing for IRQ2, zero-wait responder.
        exc_id  = 5'd18;
        exc_req = 1'b1;
        tick();
        chk("t2_ack_n1", 32'(exc_ack), 32'd1);
        chk("t2_htrans_n1", 32'(htrans), 32'd2);
        chk("t2_haddr_n1", haddr, 32'h0000_0048);
        exc_req = 1'b0;
        tick();
        chk("t2_ack_n2", 32'(exc_ack), 32'd0);
        chk("t2_valid_n2", 32'(vec_valid), 32'd0);
        tick();
        chk("t2_valid_n3", 32'(vec_valid), 32'd1);
        chk("t2_vec_addr", vec_addr, 32'h0000_0A01);
        chk("t2_vec_err", 32'(vec_err), 32'd0);
        tick();
        chk("t2_valid_n4", 32'(vec_valid), 32'd0);

        // T3: three wait states on IRQ15.
        waits[31] = 3;
        exc_id  = 5'd31;
        exc_req = 1'b1;
        tick();
        chk("t3_ack", 32'(exc_ack), 32'd1);
        chk("t3_haddr", haddr, 32'h0000_007C);
        exc_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_wait_htrans", 32'(htrans), 32'd0);
            chk("t3_wait_valid", 32'(vec_valid), 32'd0);
        end
        tick();
        chk("t3_valid", 32'(vec_valid), 32'd1);
        chk("t3_vec_addr", vec_addr, mem[31]);
        waits[31] = 0;

        // T4: every attempt errors -> failure after MAX_RETRY re-issues.
        errs_left[18] = 3;
        do_req(18);

        // Randomized lookups with random waits and occasional errors.
        for (int it = 0; it < 30; it++) begin
            id            = int'($urandom_range(31));
            mem[id]       = $urandom;
            waits[id]     = int'($urandom_range(3));
            errs_left[id] = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            do_req(id);
            repeat ($urandom_range(2)) tick();
        end

        // T5: request held across boot (with a boot retry); no early ack.
        hreset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            waits[i]     = 0;
            errs_left[i] = 0;
        end
        w0 = $urandom; w1 = $urandom; w5 = $urandom;
        mem[0] = w0; mem[1] = w1; mem[5] = w5;
        waits[0] = 1; waits[1] = 2; errs_left[0] = 1;
        exc_id  = 5'd5;
        exc_req = 1'b1;
        repeat (2) tick();
        xfer_log.delete();
        hreset = 1'b0;
        early  = 1'b0;
        n = 0;
        while (!exc_ack && n < 80) begin
            tick();
            if (exc_ack && !boot_done) early = 1'b1;
            n++;
        end
        chk("t5_no_early_ack", 32'(early), 32'd0);
        chk("t5_ack_seen", 32'(exc_ack), 32'd1);
        chk("t5_boot_done", 32'(boot_done), 32'd1);
        chk("t5_haddr", haddr, VT_BASE + 32'h0000_0014);
        chk("t5_boot_sp", boot_sp, w0);
        chk("t5_boot_pc", boot_pc, w1);
        chk("t5_boot_err", 32'(boot_err), 32'd0);
        chk("t5_boot_xfers", 32'(xfer_log.size()), 32'd3);
        exc_req = 1'b0;
        n = 0;
        while (!vec_valid && n < 50) begin
            tick();
            n++;
        end
        chk("t5_valid_seen", 32'(vec_valid), 32'd1);
        chk("t5_vec_addr", vec_addr, w5);
        waits[0] = 0; waits[1] = 0;

        // T6: asynchronous reset while the exception data phase is stalled.
        waits[20] = 6;
        exc_id  = 5'd20;
        exc_req = 1'b1;
        n = 0;
        while (!exc_ack && n < 20) begin
            tick();
            n++;
        end
        chk("t6_ack_seen", 32'(exc_ack), 32'd1);
        exc_req = 1'b0;
        repeat (2) tick();
        #1 hreset = 1'b1;
        #1;
        chk("t6_htrans", 32'(htrans), 32'd0);
        chk("t6_haddr", haddr, VT_BASE);
        chk("t6_boot_done", 32'(boot_done), 32'd0);
        chk("t6_vec_valid", 32'(vec_valid), 32'd0);
        chk("t6_boot_sp", boot_sp, 32'd0);
        repeat (2) tick();
        waits[20] = 0;
        xfer_log.delete();
        hreset = 1'b0;
        wait_boot();
        chk("t6_xfer_count", 32'(xfer_log.size()), 32'd2);
        if (xfer_log.size() == 2) begin
            chk("t6_xfer0", xfer_log[0], VT_BASE);
            chk("t6_xfer1", xfer_log[1], VT_BASE + 32'd4);
        end else begin
            chk("t6_xfer_log_shape", 32'(xfer_log.size()), 32'd2);
        end
        chk("t6_boot_sp_refetch", boot_sp, w0);

        // Boot PC fetch that fails on every attempt: boot still completes.
        hreset = 1'b1;
        errs_left[1] = 3;
        repeat (2) tick();
        xfer_log.delete();
        hreset = 1'b0;
        wait_boot();
        chk("bf_boot_err", 32'(boot_err), 32'd1);
        chk("bf_boot_pc", boot_pc, 32'd0);
        chk("bf_boot_sp", boot_sp, w0);
        chk("bf_xfer_count", 32'(xfer_log.size()), 32'd4);
        do_req(7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
